collision_engine: RTL

- Parametrised successor to the single-enemy collision detector. It checks the player and NUM_ENEMIES enemies against the level map, checks player–enemy overlap, and checks sword hits.
- Map lookups are time-multiplexed through one external levelmap ROM port. The combinational eight-ROM-instance approach is not used.
- Sits between the control FSM (start/done) and the character/enemy logic modules, which consume the registered result flags.

---
 rtl/zelda_pkg.sv | 38 +++
 rtl/corner_gen.sv | 51 +++++
 rtl/collision_engine.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zelda_pkg.sv
// rtl/zelda_pkg.sv - shared direction codes, map defaults, probe tag type and levelmap addressing
// Purpose : constants and helpers common to collision_engine, corner_gen and the
//           vga_address_translator users.
// Contents: direction codes, ON/OFF, MAP_W/MAP_H defaults, probe_tag_t,
//           addr_of(x,y) = y*320+x, is_moving(dir).
package zelda_pkg;

    localparam logic [2:0] NO_ACTION = 3'd0;
    localparam logic [2:0] ATTACK    = 3'd1;
    localparam logic [2:0] UP        = 3'd2;
    localparam logic [2:0] DOWN      = 3'd3;
    localparam logic [2:0] LEFT      = 3'd4;
    localparam logic [2:0] RIGHT     = 3'd5;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    localparam int MAP_W_DEFAULT = 256;
    localparam int MAP_H_DEFAULT = 176;

    // Travels alongside each ROM request so the answer can be credited to the
    // right entity when it comes back.
    typedef struct packed {
        logic       vld;
        logic       en;    // entity is moving; map result counts
        logic       oob;   // corner off the playfield: blocked regardless of rom_q
        logic [3:0] ent;   // 0 = player, i+1 = enemy i
    } probe_tag_t;

    function automatic logic [16:0] addr_of(input logic [8:0] x, input logic [7:0] y);
        return 17'(y) * 17'd320 + 17'(x);
    endfunction

    function automatic logic is_moving(input logic [2:0] dir);
        return (dir == UP) || (dir == DOWN) || (dir == LEFT) || (dir == RIGHT);
    endfunction

endpackage

// File: rtl/corner_gen.sv
// rtl/corner_gen.sv - combinational look-ahead corner address generator
// Purpose : displace a sprite by MOVE_PX in its move direction, pick one of its
//           four corners and translate it to a levelmap address.
// Ports   : x, y, dir    - entity position and move direction
//           corner       - 0 TL, 1 TR, 2 BL, 3 BR
//           rom_address  - y*320+x of the corner, 0 when out of bounds
//           oob          - corner lies outside 0..MAP_W / 0..MAP_H
module corner_gen
    import zelda_pkg::*;
#(
    parameter int SPRITE_SIZE = 16,
    parameter int MOVE_PX     = 1,
    parameter int MAP_W       = MAP_W_DEFAULT,
    parameter int MAP_H       = MAP_H_DEFAULT
) (
    input  logic [8:0]  x,
    input  logic [7:0]  y,
    input  logic [2:0]  dir,
    input  logic [1:0]  corner,
    output logic [16:0] rom_address,
    output logic        oob
);

    localparam logic signed [10:0] S_S = 11'(SPRITE_SIZE);
    localparam logic signed [10:0] M_S = 11'(MOVE_PX);
    localparam logic signed [10:0] W_S = 11'(MAP_W);
    localparam logic signed [10:0] H_S = 11'(MAP_H);

    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [10:0] px;
    logic signed [10:0] py;

    always_comb begin
        dx = '0;
        dy = '0;
        case (dir)
            UP:      dy = -M_S;
            DOWN:    dy = M_S;
            LEFT:    dx = -M_S;
            RIGHT:   dx = M_S;
            default: ;
        endcase
        // Signed 11-bit so a step left/up from 0 shows up as negative.
        px  = $signed({2'b00, x}) + dx + (corner[0] ? S_S : 11'sd0);
        py  = $signed({3'b000, y}) + dy + (corner[1] ? S_S : 11'sd0);
        oob = (px < 11'sd0) || (py < 11'sd0) || (px > W_S) || (py > H_S);
        rom_address = oob ? 17'd0 : addr_of(px[8:0], py[7:0]);
    end

endmodule

// File: rtl/collision_engine.sv
// rtl/collision_engine.sv - time-multiplexed player/enemy map, overlap and sword-hit checker
// Purpose : on start, snapshot positions, probe 4 look-ahead corners per entity
//           through one levelmap ROM port, then compare the player with each
//           enemy, and publish all flags together with a one-cycle done.
// Ports   : clock, reset (async, active high), start
//           char_x/char_y/char_dir/char_facing/attack - player state
//           enemy_x/enemy_y/enemy_dir - packed enemy state, enemy i at slice i
//           rom_address/rom_q - levelmap ROM port, rom_q 1 = walkable
//           busy, done - scan status
//           c_map_collision, e_map_collision, c_e_collision, e_hit - result flags
module collision_engine
    import zelda_pkg::*;
#(
    parameter int NUM_ENEMIES  = 4,
    parameter int SPRITE_SIZE  = 16,
    parameter int MOVE_PX      = 1,
    parameter int ATTACK_RANGE = 8,
    parameter int MAP_W        = MAP_W_DEFAULT,
    parameter int MAP_H        = MAP_H_DEFAULT,
    parameter int ROM_LATENCY  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [8:0]               char_x,
    input  logic [7:0]               char_y,
    input  logic [2:0]               char_dir,
    input  logic [2:0]               char_facing,
    input  logic                     attack,
    input  logic [9*NUM_ENEMIES-1:0] enemy_x,
    input  logic [8*NUM_ENEMIES-1:0] enemy_y,
    input  logic [3*NUM_ENEMIES-1:0] enemy_dir,
    output logic [16:0]              rom_address,
    input  logic                     rom_q,
    output logic                     busy,
    output logic                     done,
    output logic                     c_map_collision,
    output logic [NUM_ENEMIES-1:0]   e_map_collision,
    output logic [NUM_ENEMIES-1:0]   c_e_collision,
    output logic [NUM_ENEMIES-1:0]   e_hit
);

    localparam int N = NUM_ENEMIES;
    localparam int L = ROM_LATENCY;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PROBE   = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [5:0] PROBES     = 6'(4 * (N + 1));
    localparam logic [1:0] LAST_DRAIN = 2'(L - 1);
    localparam logic [3:0] LAST_CMP   = 4'(N - 1);
    localparam logic [8:0] S9         = 9'(SPRITE_SIZE);
    localparam logic [8:0] SR9        = 9'(SPRITE_SIZE + ATTACK_RANGE);

    logic [2:0]     state_q, state_d;
    logic [5:0]     probe_cnt_q, probe_cnt_d;
    logic [1:0]     drain_cnt_q, drain_cnt_d;
    logic [3:0]     cmp_cnt_q, cmp_cnt_d;
    logic [8:0]     cx_q, cx_d;
    logic [7:0]     cy_q, cy_d;
    logic [2:0]     cdir_q, cdir_d;
    logic [2:0]     facing_q, facing_d;
    logic           atk_q, atk_d;
    logic [9*N-1:0] ex_q, ex_d;
    logic [8*N-1:0] ey_q, ey_d;
    logic [3*N-1:0] edir_q, edir_d;
    logic [N:0]     map_sh_q, map_sh_d;    // bit 0 player, bit i+1 enemy i
    logic [N-1:0]   ce_sh_q, ce_sh_d;
    logic [N-1:0]   hit_sh_q, hit_sh_d;
    probe_tag_t     tag_q [0:L];
    probe_tag_t     tag_d [0:L];
    logic [16:0]    rom_addr_q, rom_addr_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           c_map_q, c_map_d;
    logic [N-1:0]   e_map_q, e_map_d;
    logic [N-1:0]   c_e_q, c_e_d;
    logic [N-1:0]   hit_q, hit_d;

    // The first address goes out on the accepting edge, straight from the
    // live inputs; later ones come from the snapshot.
    logic           live;
    logic           issue;
    logic [5:0]     issue_idx;
    logic [3:0]     ent;
    logic [8:0]     sel_x;
    logic [7:0]     sel_y;
    logic [2:0]     sel_dir;
    logic [9*N-1:0] src_ex;
    logic [8*N-1:0] src_ey;
    logic [3*N-1:0] src_edir;
    logic [16:0]    cg_addr;
    logic           cg_oob;

    always_comb begin
        live      = (state_q == S_IDLE);
        issue     = (live && start) || (state_q == S_PROBE && probe_cnt_q != PROBES);
        issue_idx = live ? 6'd0 : probe_cnt_q;
        ent       = issue_idx[5:2];
        src_ex    = live ? enemy_x : ex_q;
        src_ey    = live ? enemy_y : ey_q;
        src_edir  = live ? enemy_dir : edir_q;
        sel_x     = live ? char_x : cx_q;
        sel_y     = live ? char_y : cy_q;
        sel_dir   = live ? char_dir : cdir_q;
        for (int i = 0; i < N; i++) begin
            if (ent == 4'(i + 1)) begin
                sel_x   = src_ex[9*i +: 9];
                sel_y   = src_ey[8*i +: 8];
                sel_dir = src_edir[3*i +: 3];
            end
        end
    end

    corner_gen #(
        .SPRITE_SIZE (SPRITE_SIZE),
        .MOVE_PX     (MOVE_PX),
        .MAP_W       (MAP_W),
        .MAP_H       (MAP_H)
    ) u_corner_gen (
        .x           (sel_x),
        .y           (sel_y),
        .dir         (sel_dir),
        .corner      (issue_idx[1:0]),
        .rom_address (cg_addr),
        .oob         (cg_oob)
    );

    // Player versus the enemy selected by cmp_cnt_q.
    logic [8:0] ex9, ey9, cx9, cy9, ax, ay;
    logic       overlap, hit_now;

    always_comb begin
        ex9 = '0;
        ey9 = '0;
        for (int i = 0; i < N; i++) begin
            if (cmp_cnt_q == 4'(i)) begin
                ex9 = ex_q[9*i +: 9];
                ey9 = {1'b0, ey_q[8*i +: 8]};
            end
        end
        cx9     = cx_q;
        cy9     = {1'b0, cy_q};
        ax      = (cx9 >= ex9) ? cx9 - ex9 : ex9 - cx9;
        ay      = (cy9 >= ey9) ? cy9 - ey9 : ey9 - cy9;
        overlap = (ax < S9) && (ay < S9);
        hit_now = OFF;
        if (atk_q) begin
            case (facing_q)
                UP:      hit_now = (ax < S9) && (ey9 < cy9) && (cy9 - ey9 <= SR9);
                DOWN:    hit_now = (ax < S9) && (ey9 > cy9) && (ey9 - cy9 <= SR9);
                LEFT:    hit_now = (ay < S9) && (ex9 < cx9) && (cx9 - ex9 <= SR9);
                RIGHT:   hit_now = (ay < S9) && (ex9 > cx9) && (ex9 - cx9 <= SR9);
                default: hit_now = OFF;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        probe_cnt_d = probe_cnt_q;
        drain_cnt_d = drain_cnt_q;
        cmp_cnt_d   = cmp_cnt_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        cdir_d      = cdir_q;
        facing_d    = facing_q;
        atk_d       = atk_q;
        ex_d        = ex_q;
        ey_d        = ey_q;
        edir_d      = edir_q;
        map_sh_d    = map_sh_q;
        ce_sh_d     = ce_sh_q;
        hit_sh_d    = hit_sh_q;
        c_map_d     = c_map_q;
        e_map_d     = e_map_q;
        c_e_d       = c_e_q;
        hit_d       = hit_q;
        rom_addr_d  = '0;
        tag_d[0]    = '0;
        for (int j = 1; j <= L; j++) tag_d[j] = tag_q[j-1];

        if (issue) begin
            rom_addr_d = cg_addr;
            tag_d[0]   = '{vld: ON, en: is_moving(sel_dir), oob: cg_oob, ent: ent};
        end

        // The answer for the request issued L cycles ago is on rom_q now.
        if (tag_q[L].vld && tag_q[L].en && (tag_q[L].oob || !rom_q)) begin
            for (int i = 0; i <= N; i++) begin
                if (tag_q[L].ent == 4'(i)) map_sh_d[i] = ON;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cx_d        = char_x;
                    cy_d        = char_y;
                    cdir_d      = char_dir;
                    facing_d    = char_facing;
                    atk_d       = attack;
                    ex_d        = enemy_x;
                    ey_d        = enemy_y;
                    edir_d      = enemy_dir;
                    map_sh_d    = '0;
                    ce_sh_d     = '0;
                    hit_sh_d    = '0;
                    probe_cnt_d = 6'd1;
                    state_d     = S_PROBE;
                end
            end
            S_PROBE: begin
                if (probe_cnt_q == PROBES) begin
                    drain_cnt_d = '0;
                    state_d     = S_DRAIN;
                end else begin
                    probe_cnt_d = probe_cnt_q + 6'd1;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == LAST_DRAIN) begin
                    cmp_cnt_d = '0;
                    state_d   = S_COMPARE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            S_COMPARE: begin
                for (int i = 0; i < N; i++) begin
                    if (cmp_cnt_q == 4'(i)) begin
                        ce_sh_d[i]  = overlap;
                        hit_sh_d[i] = hit_now;
                    end
                end
                if (cmp_cnt_q == LAST_CMP) state_d = S_DONE;
                else                       cmp_cnt_d = cmp_cnt_q + 4'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Publish on the edge into DONE so flags and done appear together.
        done_d = (state_q == S_COMPARE) && (state_d == S_DONE);
        if (done_d) begin
            c_map_d = map_sh_d[0];
            e_map_d = map_sh_d[N:1];
            c_e_d   = ce_sh_d;
            hit_d   = hit_sh_d;
        end
        busy_d = (state_d == S_PROBE) || (state_d == S_DRAIN) || (state_d == S_COMPARE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            probe_cnt_q <= '0;
            drain_cnt_q <= '0;
            cmp_cnt_q   <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            cdir_q      <= '0;
            facing_q    <= '0;
            atk_q       <= 1'b0;
            ex_q        <= '0;
            ey_q        <= '0;
            edir_q      <= '0;
            map_sh_q    <= '0;
            ce_sh_q     <= '0;
            hit_sh_q    <= '0;
            for (int j = 0; j <= L; j++) tag_q[j] <= '0;
            rom_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            c_map_q     <= 1'b0;
            e_map_q     <= '0;
            c_e_q       <= '0;
            hit_q       <= '0;
        end else begin
            state_q     <= state_d;
            probe_cnt_q <= probe_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            cmp_cnt_q   <= cmp_cnt_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            cdir_q      <= cdir_d;
            facing_q    <= facing_d;
            atk_q       <= atk_d;
            ex_q        <= ex_d;
            ey_q        <= ey_d;
            edir_q      <= edir_d;
            map_sh_q    <= map_sh_d;
            ce_sh_q     <= ce_sh_d;
            hit_sh_q    <= hit_sh_d;
            for (int j = 0; j <= L; j++) tag_q[j] <= tag_d[j];
            rom_addr_q  <= rom_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            c_map_q     <= c_map_d;
            e_map_q     <= e_map_d;
            c_e_q       <= c_e_d;
            hit_q       <= hit_d;
        end
    end

    assign rom_address     = rom_addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign c_map_collision = c_map_q;
    assign e_map_collision = e_map_q;
    assign c_e_collision   = c_e_q;
    assign e_hit           = hit_q;

endmodule
